alu_regfile: RTL and testbench
==============================

# alu_regfile

Integer register file and scoreboard that sits on the far side of the ALU operand/result interface. It sources the `rs1`/`rs2` operands consumed by `alu_add`/`alu_sub` and accepts their `rd` result as write-back. Each register carries a busy bit, so reads of registers with a pending ALU result stall instead of returning stale data. Same-cycle write-back is forwarded onto the read outputs.

## Interface
Parameters:
- `XLEN`, 32, data width; matches the ALU operand width.
- `NREG`, 32, number of architectural registers. Register 0 is hardwired to zero.
- `AW`, 5, register address width; `2**AW == NREG`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `rd_en`  in  1  operand read request this cycle.
- `rs1_addr`  in  AW  source register 1 address.
- `rs2_addr`  in  AW  source register 2 address.
- `rs1`  out  XLEN  registered operand 1, to ALU `rs1`.
- `rs2`  out  XLEN  registered operand 2, to ALU `rs2`.
- `rs_valid`  out  1  operands on `rs1`/`rs2` are valid this cycle.
- `rs_stall`  out  1  the last read hit a busy register; the consumer must re-issue the read.
- `issue_en`  in  1  mark `issue_addr` busy (ALU op dispatched).
- `issue_addr`  in  AW  destination of the dispatched op.
- `wb_en`  in  1  write-back strobe from the ALU.
- `wb_addr`  in  AW  write-back destination.
- `rd`  in  XLEN  write-back data, from ALU `rd`.
- `busy_any`  out  1  OR of all busy bits, registered.

## Operation
- **Reset** (`reset`=0 at an edge):
  - Every register, every busy bit, `rs1`, `rs2`, `rs_valid`, `rs_stall` and `busy_any` become 0.
  - Reset overrides all other inputs in the same cycle.
  - Reset asserted mid-stall or mid-write discards that operation.
- **Write:** `wb_en`=1 writes `rd` to `reg[wb_addr]` and clears `busy[wb_addr]`. A write-back to a register that is not busy is legal and writes normally.
- **Issue:** `issue_en`=1 sets `busy[issue_addr]`.
  - Issue and write-back to the same address in the same cycle: data is written and busy ends at 1 (issue wins; a new producer is pending).
- **Register 0:**
  - Reads always return 0.
  - Writes are ignored.
  - Issue to register 0 is ignored; its busy bit is never set.
- **Effective busy, per source `s` in the read cycle:** `busy[s]` and not (`wb_en` and `wb_addr`==s). Issue in the same cycle does not affect the stall decision of that cycle.
- **Read, `rd_en`=1:**
  - Either source effectively busy: `rs_valid`=0, `rs_stall`=1, `rs1`/`rs2` hold their previous values.
  - Otherwise: `rs_valid`=1, `rs_stall`=0, `rs1`/`rs2` are loaded.
- **Forwarding:** if `wb_en` and `wb_addr`==source addr and the addr is nonzero, the output takes `rd`; otherwise it takes `reg[addr]`.
- **`rd_en`=0:** `rs_valid`=0, `rs_stall`=0, data holds.
- **Arithmetic:** none. Values are stored bit-exact; sign is irrelevant to this block.

## Timing
- Read latency is 1 cycle: a request in cycle N produces `rs1`/`rs2`/`rs_valid`/`rs_stall` in cycle N+1.
- `rs_valid` and `rs_stall` are mutually exclusive and each is asserted for one cycle per request.
- A write in cycle N is visible:
  - via forwarding, to a read in cycle N;
  - from the array, to any later read.
- Busy-bit changes take effect for reads in cycle N+1 and later, except the write-back clear, which is effective in cycle N.
- `busy_any` reflects the busy bits after the edge, i.e. it lags one cycle.
- There is no backpressure on write-back or issue; both are accepted every cycle.

## Test plan
- **Reset state:** hold `reset`=0 for 2 cycles, then read r1,r2 -> `rs1`=0, `rs2`=0, `rs_valid`=1; before the read, `busy_any`=0.
- **Write then read:** wb r3=71, r4=82; then read r3,r4 -> `rs1`=71, `rs2`=82. Wb r5=-71 (0xFFFF_FFB9); read r5,r0 -> `rs1`=0xFFFF_FFB9, `rs2`=0.
- **Register 0 protection:** wb r0=82 and issue r0; read r0,r0 -> both 0, `rs_valid`=1, `busy_any`=0.
- **Stall and release:**
  - issue r6; next cycle read r6,r3 -> `rs_stall`=1, `rs_valid`=0, data held;
  - read r6 with wb r6=153 in the same cycle -> `rs_valid`=1, `rs1`=153 (forwarded); `busy_any` returns to 0.
- **Simultaneous issue+wb:** issue r7 and wb r7=11 together; next cycle read r7 -> `rs_stall`=1; after wb r7=22, read -> `rs1`=22.
- **Reset mid-stall:** issue r8, read r8 (stall), then `reset`=0 for one edge -> all outputs 0; read r8 -> `rs1`=0, `rs_valid`=1.

Source files
------------

// File: rtl/alu_regfile_if.sv
// Operand-read, issue and write-back bus between the ALU pipeline and alu_regfile.
// The master side (pipeline) drives requests; the slave side (register file) answers.
interface alu_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            rd_en;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            rs_valid;
  logic            rs_stall;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] rd;
  logic            busy_any;

  modport master (
    output rd_en, rs1_addr, rs2_addr, issue_en, issue_addr, wb_en, wb_addr, rd,
    input  rs1, rs2, rs_valid, rs_stall, busy_any
  );

  modport slave (
    input  rd_en, rs1_addr, rs2_addr, issue_en, issue_addr, wb_en, wb_addr, rd,
    output rs1, rs2, rs_valid, rs_stall, busy_any
  );
endinterface

// File: rtl/alu_regfile.sv
// Integer register file with per-register busy scoreboard: reads of a register
// awaiting an ALU result stall, and same-cycle write-back is forwarded to reads.
module alu_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic         clk,
  input  logic         reset,
  alu_regfile_if.slave bus
);

  logic [XLEN-1:0] reg_q [NREG];
  logic [XLEN-1:0] reg_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            rs_valid_q, rs_valid_d;
  logic            rs_stall_q, rs_stall_d;
  logic            busy_any_q, busy_any_d;

  logic            wb_live;
  logic            hit1, hit2;
  logic            eff_busy1, eff_busy2;
  logic [XLEN-1:0] fwd1, fwd2;

  // Source lookup: a same-cycle write-back both supplies the data and cancels the busy bit.
  always_comb begin
    wb_live   = bus.wb_en && (bus.wb_addr != '0);
    hit1      = wb_live && (bus.wb_addr == bus.rs1_addr);
    hit2      = wb_live && (bus.wb_addr == bus.rs2_addr);
    eff_busy1 = busy_q[bus.rs1_addr] && !hit1;
    eff_busy2 = busy_q[bus.rs2_addr] && !hit2;
    fwd1      = (bus.rs1_addr == '0) ? '0 : (hit1 ? bus.rd : reg_q[bus.rs1_addr]);
    fwd2      = (bus.rs2_addr == '0) ? '0 : (hit2 ? bus.rd : reg_q[bus.rs2_addr]);
  end

  // NOTE: every *_d gets its hold value first, so no path leaves a signal unassigned (no latch).
  always_comb begin
    reg_d      = reg_q;
    busy_d     = busy_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs_valid_d = 1'b0;
    rs_stall_d = 1'b0;

    if (bus.rd_en) begin
      if (eff_busy1 || eff_busy2) begin
        rs_stall_d = 1'b1;
      end else begin
        rs_valid_d = 1'b1;
        rs1_d      = fwd1;
        rs2_d      = fwd2;
      end
    end

    if (wb_live) begin
      reg_d[bus.wb_addr]  = bus.rd;
      busy_d[bus.wb_addr] = 1'b0;
    end
    // Issue is applied after write-back so a new producer to the same register stays pending.
    if (bus.issue_en && (bus.issue_addr != '0)) begin
      busy_d[bus.issue_addr] = 1'b1;
    end

    busy_any_d = |busy_d;
  end

  // NOTE: state flops use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the register array is reset too, because software-visible contents must read 0 after reset.
      for (int i = 0; i < NREG; i++) begin
        reg_q[i] <= '0;
      end
      busy_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs_valid_q <= 1'b0;
      rs_stall_q <= 1'b0;
      busy_any_q <= 1'b0;
    end else begin
      reg_q      <= reg_d;
      busy_q     <= busy_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs_valid_q <= rs_valid_d;
      rs_stall_q <= rs_stall_d;
      busy_any_q <= busy_any_d;
    end
  end

  assign bus.rs1      = rs1_q;
  assign bus.rs2      = rs2_q;
  assign bus.rs_valid = rs_valid_q;
  assign bus.rs_stall = rs_stall_q;
  assign bus.busy_any = busy_any_q;

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile: a register/busy-set model predicts every output
// each cycle, and literal expectations pin the main scenarios.
module tb_alu_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk;
  logic reset;

  alu_regfile_if #(.XLEN(XLEN), .AW(AW)) bus ();

  alu_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the architectural state and the read answer must be.
  logic [XLEN-1:0] model_reg  [NREG];
  bit              model_busy [NREG];
  logic [XLEN-1:0] exp_rs1, exp_rs2;
  logic            exp_valid, exp_stall, exp_busy_any;
  bit              model_ready = 1'b0;

  function automatic logic [XLEN-1:0] source_value(input int a);
    if (a == 0) return '0;
    if (bus.wb_en && int'(bus.wb_addr) == a) return bus.rd;
    return model_reg[a];
  endfunction

  function automatic bit source_blocked(input int a);
    return model_busy[a] && !(bus.wb_en && int'(bus.wb_addr) == a);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        model_reg[i]  = '0;
        model_busy[i] = 1'b0;
      end
      exp_rs1 = '0; exp_rs2 = '0;
      exp_valid = 1'b0; exp_stall = 1'b0; exp_busy_any = 1'b0;
      model_ready = 1'b1;
    end else begin
      int a1, a2, wa, ia;
      a1 = int'(bus.rs1_addr);
      a2 = int'(bus.rs2_addr);
      wa = int'(bus.wb_addr);
      ia = int'(bus.issue_addr);
      exp_valid = 1'b0;
      exp_stall = 1'b0;
      if (bus.rd_en) begin
        if (source_blocked(a1) || source_blocked(a2)) begin
          exp_stall = 1'b1;
        end else begin
          exp_valid = 1'b1;
          exp_rs1   = source_value(a1);
          exp_rs2   = source_value(a2);
        end
      end
      if (bus.wb_en && wa != 0) begin
        model_reg[wa]  = bus.rd;
        model_busy[wa] = 1'b0;
      end
      if (bus.issue_en && ia != 0) model_busy[ia] = 1'b1;
      exp_busy_any = 1'b0;
      for (int i = 0; i < NREG; i++) if (model_busy[i]) exp_busy_any = 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      check("cmp_rs1",      bus.rs1,      exp_rs1);
      check("cmp_rs2",      bus.rs2,      exp_rs2);
      check("cmp_rs_valid", XLEN'(bus.rs_valid), XLEN'(exp_valid));
      check("cmp_rs_stall", XLEN'(bus.rs_stall), XLEN'(exp_stall));
      check("cmp_busy_any", XLEN'(bus.busy_any), XLEN'(exp_busy_any));
    end
  end

  // One clock of stimulus, driven at the falling edge; returns at the next falling edge.
  task automatic cyc(input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic ie, input logic [AW-1:0] ia,
                     input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] d);
    bus.rd_en      = r;
    bus.rs1_addr   = a1;
    bus.rs2_addr   = a2;
    bus.issue_en   = ie;
    bus.issue_addr = ia;
    bus.wb_en      = we;
    bus.wb_addr    = wa;
    bus.rd         = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cyc(1'b1, a1, a2, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic wb(input logic [AW-1:0] wa, input logic [XLEN-1:0] d);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, wa, d);
  endtask

  task automatic expect_read(input string name, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                             input logic v, input logic s);
    check({name, "_rs1"},   bus.rs1, e1);
    check({name, "_rs2"},   bus.rs2, e2);
    check({name, "_valid"}, XLEN'(bus.rs_valid), XLEN'(v));
    check({name, "_stall"}, XLEN'(bus.rs_stall), XLEN'(s));
  endtask

  initial begin
    reset = 1'b0;
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    expect_read("reset", 32'd0, 32'd0, 1'b0, 1'b0);
    check("reset_busy_any", XLEN'(bus.busy_any), 32'd0);
    reset = 1'b1;

    read(5'd1, 5'd2);
    expect_read("rd_after_reset", 32'd0, 32'd0, 1'b1, 1'b0);

    wb(5'd3, 32'd71);
    wb(5'd4, 32'd82);
    read(5'd3, 5'd4);
    expect_read("wr_rd", 32'd71, 32'd82, 1'b1, 1'b0);
    wb(5'd5, 32'hFFFF_FFB9);
    read(5'd5, 5'd0);
    expect_read("neg_r0", 32'hFFFF_FFB9, 32'd0, 1'b1, 1'b0);

    cyc(1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0, 32'd82);
    read(5'd0, 5'd0);
    expect_read("r0_protect", 32'd0, 32'd0, 1'b1, 1'b0);
    check("r0_busy_any", XLEN'(bus.busy_any), 32'd0);

    // Issue r6 while reading r3,r4; the issue must not affect this read.
    cyc(1'b1, 5'd3, 5'd4, 1'b1, 5'd6, 1'b0, '0, '0);
    expect_read("issue_same_cyc", 32'd71, 32'd82, 1'b1, 1'b0);
    check("issue_busy_any", XLEN'(bus.busy_any), 32'd1);
    read(5'd6, 5'd3);
    expect_read("stall_hold", 32'd71, 32'd82, 1'b0, 1'b1);
    cyc(1'b1, 5'd6, 5'd3, 1'b0, '0, 1'b1, 5'd6, 32'd153);
    expect_read("fwd_release", 32'd153, 32'd71, 1'b1, 1'b0);
    check("release_busy_any", XLEN'(bus.busy_any), 32'd0);

    cyc(1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd7, 32'd11);
    read(5'd7, 5'd0);
    expect_read("iss_wb_same", 32'd153, 32'd71, 1'b0, 1'b1);
    wb(5'd7, 32'd22);
    read(5'd7, 5'd0);
    expect_read("iss_wb_done", 32'd22, 32'd0, 1'b1, 1'b0);

    cyc(1'b1, 5'd9, 5'd0, 1'b0, '0, 1'b1, 5'd9, 32'd5);
    expect_read("fwd_idle_reg", 32'd5, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    expect_read("no_req", 32'd5, 32'd0, 1'b0, 1'b0);

    cyc(1'b0, '0, '0, 1'b1, 5'd8, 1'b0, '0, '0);
    read(5'd8, 5'd0);
    expect_read("pre_reset_stall", 32'd5, 32'd0, 1'b0, 1'b1);
    reset = 1'b0;
    cyc(1'b1, 5'd8, 5'd3, 1'b1, 5'd10, 1'b1, 5'd8, 32'd77);
    expect_read("mid_reset", 32'd0, 32'd0, 1'b0, 1'b0);
    check("mid_reset_busy_any", XLEN'(bus.busy_any), 32'd0);
    reset = 1'b1;
    read(5'd8, 5'd3);
    expect_read("post_reset", 32'd0, 32'd0, 1'b1, 1'b0);
    read(5'd10, 5'd4);
    expect_read("post_reset_b", 32'd0, 32'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
